// File: rtl/ila_proc_gen_pkg.sv
// Shared definitions for the parametrised ILA processor: opcodes, decode bit
// positions, FSM states and a constant-evaluable clog2.
package ila_proc_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_BNZ   = 3'b100;
    localparam logic [2:0] OP_LI    = 3'b101;
    localparam logic [2:0] OP_ILL   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int DEC_LOAD  = 0;
    localparam int DEC_ADD   = 1;
    localparam int DEC_STORE = 2;
    localparam int DEC_SUB   = 3;
    localparam int DEC_BNZ   = 4;
    localparam int DEC_HALT  = 5;
    localparam int NDEC      = 6;

    typedef enum logic [1:0] {
        RUN,
        LOAD_WB,
        HALTED
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Li shares the load decode bit; the illegal opcode decodes to nothing.
    function automatic logic [NDEC-1:0] decode(input logic [2:0] op);
        logic [NDEC-1:0] d;
        d = '0;
        case (op)
            OP_LOAD, OP_LI: d[DEC_LOAD]  = 1'b1;
            OP_ADD:         d[DEC_ADD]   = 1'b1;
            OP_STORE:       d[DEC_STORE] = 1'b1;
            OP_SUB:         d[DEC_SUB]   = 1'b1;
            OP_BNZ:         d[DEC_BNZ]   = 1'b1;
            OP_HALT:        d[DEC_HALT]  = 1'b1;
            default:        d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ila_proc_gen_if.sv
// Control/observation bundle of the ILA processor. The harness drives the
// master side, the processor sits on the slave side.
interface ila_proc_gen_if #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = 8
);
    import ila_proc_pkg::*;

    localparam int RW = clog2(NREG);
    localparam int IW = 3 + 3 * RW;

    logic [NDEC-1:0]    grant;
    logic               resume;
    logic               imem_we;
    logic [AW-1:0]      imem_addr;
    logic [IW-1:0]      imem_wdata;
    logic               valid;
    logic [NDEC-1:0]    acc_decode;
    logic [AW-1:0]      pc;
    logic [NREG*DW-1:0] regs;
    logic               retire;
    logic               halted;
    logic               illegal;

    modport master (
        output grant, resume, imem_we, imem_addr, imem_wdata,
        input  valid, acc_decode, pc, regs, retire, halted, illegal
    );

    modport slave (
        input  grant, resume, imem_we, imem_addr, imem_wdata,
        output valid, acc_decode, pc, regs, retire, halted, illegal
    );

endinterface

// File: rtl/ila_proc_regfile.sv
// NREG x DW register file: two asynchronous read ports, one write port,
// asynchronous reset to zero, and a flattened view with r0 in the LSBs.
module ila_proc_regfile
    import ila_proc_pkg::*;
#(
    parameter  int DW   = 8,
    parameter  int NREG = 4,
    localparam int RW   = clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RW-1:0]      ra_addr,
    input  logic [RW-1:0]      rb_addr,
    output logic [DW-1:0]      ra_data,
    output logic [DW-1:0]      rb_data,
    input  logic               we,
    input  logic [RW-1:0]      wa,
    input  logic [DW-1:0]      wd,
    output logic [NREG*DW-1:0] regs
);

    logic [DW-1:0] mem [NREG];

    // Register write with asynchronous clear.
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs[g*DW +: DW] = mem[g];
    end

endmodule

// File: rtl/ila_proc_gen.sv
// Parametrised ILA reference processor: single-issue, grant-gated commit,
// two-cycle loads through a registered data-memory read, halt/resume.
module ila_proc_gen
    import ila_proc_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = 8
) (
    input logic           clk,
    input logic           rst,
    ila_proc_gen_if.slave bus
);

    localparam int RW   = clog2(NREG);
    localparam int IW   = 3 + 3 * RW;
    localparam int IMMW = 2 * RW;

    logic [IW-1:0] imem [2**AW];
    logic [DW-1:0] dmem [2**AW];

    state_t          state, state_next;
    logic [AW-1:0]   pc_q, pc_next;
    logic [IW-1:0]   ir;
    logic [2:0]      opcode;
    logic [RW-1:0]   rd, rs1, rs2;
    logic [IMMW-1:0] imm;
    logic [AW-1:0]   addr;
    logic [NDEC-1:0] dec;
    logic            go;
    logic [RW-1:0]   ra_addr;
    logic [DW-1:0]   ra_data, rb_data;
    logic            rf_we;
    logic [RW-1:0]   rf_wa;
    logic [DW-1:0]   rf_wd;
    logic [DW-1:0]   rdata_q;
    logic [RW-1:0]   ld_rd_q;
    logic            ld_issue, dmem_we, commit, set_illegal;
    logic            retire_q, illegal_q;

    // Fetch/decode: asynchronous read so a same-cycle imem write is seen next cycle.
    assign ir      = imem[pc_q];
    assign opcode  = ir[IW-1 -: 3];
    assign rd      = ir[IW-4 -: RW];
    assign rs1     = ir[2*RW-1 -: RW];
    assign rs2     = ir[RW-1:0];
    assign imm     = {rs1, rs2};
    assign addr    = AW'(imm);
    assign dec     = decode(opcode);
    assign go      = |(dec & bus.grant);
    assign ra_addr = (opcode == OP_STORE || opcode == OP_BNZ) ? rd : rs1;

    ila_proc_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ra_addr),
        .rb_addr (rs2),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (rf_we),
        .wa      (rf_wa),
        .wd      (rf_wd),
        .regs    (bus.regs)
    );

    // Next-state, next-pc and datapath controls for each FSM state.
    // NOTE: every output gets a default first so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_next  = state;
        pc_next     = pc_q;
        rf_we       = 1'b0;
        rf_wa       = rd;
        rf_wd       = '0;
        dmem_we     = 1'b0;
        ld_issue    = 1'b0;
        commit      = 1'b0;
        set_illegal = 1'b0;
        case (state)
            RUN: begin
                if (opcode == OP_ILL) begin
                    set_illegal = 1'b1;
                    pc_next     = pc_q + 1'b1;
                end else if (go) begin
                    commit  = 1'b1;
                    pc_next = pc_q + 1'b1;
                    case (opcode)
                        OP_LOAD: begin
                            commit     = 1'b0;
                            ld_issue   = 1'b1;
                            pc_next    = pc_q;
                            state_next = LOAD_WB;
                        end
                        OP_ADD: begin
                            rf_we = 1'b1;
                            rf_wd = ra_data + rb_data;
                        end
                        OP_SUB: begin
                            rf_we = 1'b1;
                            rf_wd = ra_data - rb_data;
                        end
                        OP_LI: begin
                            rf_we = 1'b1;
                            rf_wd = DW'(imm);
                        end
                        OP_STORE: dmem_we = 1'b1;
                        OP_BNZ:   if (ra_data != '0) pc_next = addr;
                        OP_HALT:  state_next = HALTED;
                        default:  commit = 1'b0;
                    endcase
                end
            end
            LOAD_WB: begin
                rf_we      = 1'b1;
                rf_wa      = ld_rd_q;
                rf_wd      = rdata_q;
                pc_next    = pc_q + 1'b1;
                commit     = 1'b1;
                state_next = RUN;
            end
            HALTED: begin
                if (bus.resume) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Architectural state: FSM, pc, retire pulse, sticky illegal, pending load target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pc_q      <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            ld_rd_q   <= '0;
        end else begin
            state    <= state_next;
            pc_q     <= pc_next;
            retire_q <= commit;
            if (set_illegal) illegal_q <= 1'b1;
            if (ld_issue)    ld_rd_q   <= rd;
        end
    end

    // Instruction/data memory writes and the registered data-memory read.
    // NOTE: memories and their read register carry no reset; contents are defined by writes only.
    always_ff @(posedge clk) begin
        if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
        if (dmem_we)     dmem[addr] <= ra_data;
        if (ld_issue)    rdata_q <= dmem[addr];
    end

    assign bus.valid      = (state == RUN);
    assign bus.halted     = (state == HALTED);
    assign bus.acc_decode = dec;
    assign bus.pc         = pc_q;
    assign bus.retire     = retire_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_ila_proc_gen.sv
// Self-checking bench for ila_proc_gen: directed programs plus a randomized
// program/grant run, compared every cycle against an instruction-level model.
module tb_ila_proc_gen;

    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int AW   = 8;
    localparam int IW   = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ila_proc_gen_if #(.DW(DW), .NREG(NREG), .AW(AW)) bus ();

    ila_proc_gen #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model state
    logic [IW-1:0] mi [256];
    logic [DW-1:0] md [256];
    logic [DW-1:0] mr [NREG];
    logic [AW-1:0] mpc;
    bit            m_ret, m_halt, m_ill, m_ld;
    logic [1:0]    m_ldrd;
    logic [DW-1:0] m_ldval;

    function automatic logic [IW-1:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                          input logic [1:0] s1, input logic [1:0] s2);
        return {op, rd, s1, s2};
    endfunction

    function automatic logic [IW-1:0] enc_i(input logic [2:0] op, input logic [1:0] rd,
                                            input logic [3:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [5:0] exp_dec(input logic [2:0] op);
        logic [5:0] d;
        d = '0;
        case (op)
            3'd0, 3'd5: d[0] = 1'b1;
            3'd1:       d[1] = 1'b1;
            3'd2:       d[2] = 1'b1;
            3'd3:       d[3] = 1'b1;
            3'd4:       d[4] = 1'b1;
            3'd7:       d[5] = 1'b1;
            default:    d = '0;
        endcase
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mr[i] = '0;
        mpc = '0; m_ret = 0; m_halt = 0; m_ill = 0; m_ld = 0;
    endtask

    // One clock edge of architectural behaviour given this cycle's grant/resume.
    task automatic model_step(input logic [5:0] g, input logic res);
        logic [IW-1:0] w;
        logic [2:0]    op;
        logic [1:0]    rd, s1, s2;
        logic [3:0]    imm;
        w = mi[mpc]; op = w[8:6]; rd = w[5:4]; s1 = w[3:2]; s2 = w[1:0]; imm = w[3:0];
        m_ret = 0;
        if (m_halt) begin
            if (res) m_halt = 0;
        end else if (m_ld) begin
            mr[m_ldrd] = m_ldval; mpc = mpc + 8'd1; m_ret = 1; m_ld = 0;
        end else begin
            case (op)
                3'd0: if (g[0]) begin m_ld = 1; m_ldrd = rd; m_ldval = md[imm]; end
                3'd1: if (g[1]) begin mr[rd] = mr[s1] + mr[s2]; mpc = mpc + 8'd1; m_ret = 1; end
                3'd2: if (g[2]) begin md[imm] = mr[rd]; mpc = mpc + 8'd1; m_ret = 1; end
                3'd3: if (g[3]) begin mr[rd] = mr[s1] - mr[s2]; mpc = mpc + 8'd1; m_ret = 1; end
                3'd4: if (g[4]) begin
                    mpc = (mr[rd] != 8'd0) ? {4'd0, imm} : mpc + 8'd1; m_ret = 1;
                end
                3'd5: if (g[0]) begin mr[rd] = {4'd0, imm}; mpc = mpc + 8'd1; m_ret = 1; end
                3'd6: begin m_ill = 1; mpc = mpc + 8'd1; end
                default: if (g[5]) begin mpc = mpc + 8'd1; m_halt = 1; m_ret = 1; end
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [NREG*DW-1:0] er;
        for (int i = 0; i < NREG; i++) er[i*DW +: DW] = mr[i];
        check({tag, "_pc"},     bus.pc,         mpc);
        check({tag, "_regs"},   bus.regs,       er);
        check({tag, "_retire"}, bus.retire,     m_ret);
        check({tag, "_halted"}, bus.halted,     m_halt);
        check({tag, "_valid"},  bus.valid,      !(m_halt || m_ld));
        check({tag, "_ill"},    bus.illegal,    m_ill);
        check({tag, "_dec"},    bus.acc_decode, exp_dec(mi[mpc][8:6]));
    endtask

    task automatic step(input logic [5:0] g, input logic res, input string tag);
        bus.grant  = g;
        bus.resume = res;
        @(posedge clk);
        model_step(g, res);
        #1;
        check_all(tag);
    endtask

    // Write the whole instruction memory under reset, then release and check reset state.
    task automatic load_prog(input logic [IW-1:0] prog [$]);
        logic [IW-1:0] w;
        rst = 1'b1;
        bus.imem_we = 1'b1;
        for (int a = 0; a < 256; a++) begin
            w = (a < prog.size()) ? prog[a] : enc(3'd1, 2'd0, 2'd0, 2'd0);
            bus.imem_addr  = a[7:0];
            bus.imem_wdata = w;
            mi[a] = w;
            @(posedge clk);
            #1;
        end
        bus.imem_we = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("reset");
    endtask

    initial begin
        logic [IW-1:0] prog [$];
        int            nret;
        logic [2:0]    op;

        rst = 1'b1;
        bus.grant = '0; bus.resume = 1'b0; bus.imem_we = 1'b0;
        bus.imem_addr = '0; bus.imem_wdata = '0;

        // Program A: arithmetic, stall, store/load, wraps, branches
        prog = {};
        prog.push_back(enc_i(3'd5, 2'd1, 4'hF));
        prog.push_back(enc_i(3'd5, 2'd2, 4'h1));
        prog.push_back(enc(3'd1, 2'd3, 2'd1, 2'd2));
        prog.push_back(enc_i(3'd2, 2'd3, 4'h5));
        prog.push_back(enc_i(3'd0, 2'd0, 4'h5));
        prog.push_back(enc_i(3'd5, 2'd0, 4'h0));
        prog.push_back(enc(3'd3, 2'd0, 2'd0, 2'd2));
        for (int i = 0; i < 4; i++) prog.push_back(enc(3'd1, 2'd1, 2'd1, 2'd1));
        prog.push_back(enc(3'd1, 2'd1, 2'd1, 2'd3));
        prog.push_back(enc_i(3'd4, 2'd1, 4'hC));
        prog.push_back(enc_i(3'd5, 2'd1, 4'h5));
        prog.push_back(enc_i(3'd4, 2'd1, 4'hC));
        load_prog(prog);
        check("a_reset_valid", bus.valid, 1'b1);

        nret = 0;
        step(6'h3F, 1'b0, "li1"); nret += int'(bus.retire);
        step(6'h3F, 1'b0, "li2"); nret += int'(bus.retire);
        for (int i = 0; i < 3; i++) begin
            step(6'h3D, 1'b0, "stall"); nret += int'(bus.retire);
        end
        check("stall_pc", bus.pc, 8'd2);
        step(6'h02, 1'b0, "add"); nret += int'(bus.retire);
        check("a_r3", bus.regs[31:24], 8'h10);
        check("a_pc3", bus.pc, 8'd3);
        check("a_retires", nret, 3);
        step(6'h3F, 1'b0, "store");
        step(6'h3F, 1'b0, "ld_issue");
        check("ldwb_valid", bus.valid, 1'b0);
        step(6'h00, 1'b0, "ld_wb");
        check("ld_r0", bus.regs[7:0], 8'h10);
        check("ld_pc", bus.pc, 8'd5);
        step(6'h3F, 1'b0, "li0");
        step(6'h3F, 1'b0, "sub");
        check("sub_wrap", bus.regs[7:0], 8'hFF);
        for (int i = 0; i < 4; i++) step(6'h3F, 1'b0, "dbl");
        check("r1_f0", bus.regs[15:8], 8'hF0);
        step(6'h3F, 1'b0, "add_wrap");
        check("add_wrap_r1", bus.regs[15:8], 8'h00);
        step(6'h3F, 1'b0, "bnz0");
        check("bnz_nt_pc", bus.pc, 8'd13);
        step(6'h3F, 1'b0, "li5");
        step(6'h3F, 1'b0, "bnz5");
        check("bnz_t_pc", bus.pc, 8'h0C);

        // Program B: halt/resume, illegal, pc wrap
        prog = {};
        prog.push_back(enc_i(3'd5, 2'd1, 4'h3));
        prog.push_back(enc(3'd7, 2'd0, 2'd0, 2'd0));
        prog.push_back(enc(3'd6, 2'd0, 2'd0, 2'd0));
        prog.push_back(enc_i(3'd5, 2'd2, 4'h1));
        load_prog(prog);
        step(6'h3F, 1'b0, "b_li");
        step(6'h3F, 1'b0, "halt");
        check("halt_halted", bus.halted, 1'b1);
        check("halt_valid", bus.valid, 1'b0);
        for (int i = 0; i < 3; i++) step(6'h3F, 1'b0, "halted");
        check("halt_pc", bus.pc, 8'd2);
        step(6'h3F, 1'b1, "resume");
        check("resume_valid", bus.valid, 1'b1);
        step(6'h00, 1'b0, "illegal");
        check("illegal_set", bus.illegal, 1'b1);
        check("illegal_pc", bus.pc, 8'd3);
        for (int i = 0; i < 252; i++) step(6'h3F, 1'(i % 5 == 0), "run");
        check("pc_ff", bus.pc, 8'hFF);
        step(6'h3F, 1'b0, "wrap");
        check("pc_wrap", bus.pc, 8'h00);
        check("illegal_sticky", bus.illegal, 1'b1);

        // Program C: reset asserted during LOAD_WB
        prog = {};
        prog.push_back(enc_i(3'd0, 2'd0, 4'h5));
        load_prog(prog);
        step(6'h3F, 1'b0, "c_issue");
        #2 rst = 1'b1;
        #1;
        check("rst_ld_r0", bus.regs[7:0], 8'h00);
        check("rst_ld_pc", bus.pc, 8'h00);
        check("rst_ld_valid", bus.valid, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_all("c_post_rst");
        step(6'h3F, 1'b0, "c_issue2");
        step(6'h3F, 1'b0, "c_wb2");
        check("c_r0", bus.regs[7:0], 8'h10);

        // Random: preamble initialises dmem[0..15], then random instructions
        prog = {};
        for (int k = 0; k < 16; k++) begin
            prog.push_back(enc_i(3'd5, 2'd0, 4'(k)));
            prog.push_back(enc_i(3'd2, 2'd0, 4'(k)));
        end
        for (int a = 32; a < 256; a++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd6 && $urandom_range(0, 7) != 0) op = 3'd1;
            prog.push_back({op, 6'($urandom)});
        end
        load_prog(prog);
        for (int i = 0; i < 3000; i++)
            step(6'($urandom) | 6'($urandom), 1'($urandom_range(0, 2) == 0), "rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ila_proc_gen.md
# ila_proc_gen

Parametrised successor to the single-cycle ILA-generated Load/Add/Store processor model. It has configurable data width, register count and address width, and a richer instruction set: load-immediate, subtract, branch-if-nonzero and halt. Loads take two cycles through a registered data-memory read. Each instruction commits only when its decode bit and the matching grant bit are both high. The block sits under the ILA refinement harness as the reference datapath for multi-instruction, multi-cycle checks.

## Interface
- DW, 8, data and register width
- NREG, 4, register count (power of two, ≥2); RW = clog2(NREG)
- AW, 8, instruction and data address width; both memories hold 2^AW entries
- IW, 3+3·RW (derived), instruction width: [IW-1:IW-3] opcode, then rd, rs1, rs2 fields of RW bits each
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- grant  in  6  per-instruction commit enable, indexed like decode
- resume  in  1  pulse that leaves HALTED
- imem_we  in  1  instruction-memory write enable
- imem_addr  in  AW  instruction-memory write address
- imem_wdata  in  IW  instruction-memory write data
- valid  out  1  high in RUN only
- acc_decode  out  6  one-hot decode of ir[pc]: 0 Load, 1 Add, 2 Store, 3 Sub, 4 Bnz, 5 Halt (Li reported on bit 0 as a load variant)
- pc  out  AW  program counter
- regs  out  NREG·DW  flattened register file, r0 in the LSBs
- retire  out  1  registered; high one cycle after each commit edge
- halted  out  1  high in HALTED
- illegal  out  1  sticky; set on opcode 110

## Operation
- Opcodes: 000 Load, 001 Add, 010 Store, 011 Sub, 100 Bnz, 101 Li, 110 illegal, 111 Halt.
- Address/immediate field is {rs1,rs2} (2·RW bits), zero-extended to AW or DW.
- Load: rd ← dmem[addr]. Store: dmem[addr] ← r[rd]. Add/Sub: rd ← r[rs1] ± r[rs2], mod 2^DW. Li: rd ← imm.
- Bnz: if r[rd] ≠ 0 then pc ← addr, else pc ← pc+1.
- Halt: pc ← pc+1, then enter HALTED.
- All other instructions: pc ← pc+1, wrapping 2^AW−1 → 0.
- FSM RUN: decode ir[pc]. If the decoded bit AND grant[bit] is 0, stall with no state change.
  - Load with grant: issue dmem read, go to LOAD_WB.
  - Other granted instructions commit at the clock edge.
  - Illegal opcode needs no grant: set `illegal`, pc+1.
- FSM LOAD_WB: write rd from registered read data, pc+1, return to RUN. grant is ignored.
- FSM HALTED: hold all state. resume moves to RUN on the next edge.
- Reset: pc=0, regs=0, state RUN, retire=0, halted=0, illegal=0.
  - valid=1 and acc_decode reflects ir[0] immediately after release.
  - Memories are not reset.

## Timing
- Single-cycle instructions: commit at the edge ending the granted cycle; retire high in the following cycle.
- Load: granted cycle N issues the read; rd and pc update at the end of N+1; retire high in N+2.
- imem write and fetch of the same address in the same cycle: fetch returns the old word; the new word is visible next cycle.
- Store followed by Load of the same address: the Load sees the stored value. Single issue gives no overlap.
- grant changes during LOAD_WB have no effect.
- rst asserted mid-Load: rd is not written, the FSM returns to RUN, and all outputs take their reset values asynchronously.
- resume while not HALTED: ignored.

## Structure
- Package ila_proc_pkg holds:
  - opcode localparams
  - FSM state enum (RUN, LOAD_WB, HALTED)
  - decode bit indices
  - a clog2 function
- Sub-module ila_proc_regfile: NREG×DW, two async read ports, one write port, async reset to zero.
- Memories are inferred arrays in the top module.

## Test plan
All scenarios use DW=8, NREG=4, AW=8, grant=6'h3F unless stated.
- Li r1,0x0F; Li r2,0x01; Add r3,r1,r2 -> r3=0x10, pc=3, three retire pulses.
- Store r3@0x5; Load r0@0x5 -> r0=0x10 at the end of the cycle after the Load grant; valid=0 during LOAD_WB.
- Wrap checks:
  - Li r1,0xF ×... building 0xF0, then Add with 0x10 -> 0x00.
  - Sub 0−1 -> 0xFF.
  - pc at 0xFF executing Add -> pc=0x00.
- Add decoded with grant=0 for 3 cycles -> pc and regs unchanged, retire=0; grant[1]=1 -> commit.
- Bnz r1,0x0C: with r1=0 -> pc+1; with r1=5 -> pc=0x0C.
- Halt and errors:
  - Halt -> halted=1, valid=0, pc frozen; resume -> RUN next cycle.
  - Opcode 110 -> illegal=1 sticky.
  - rst during LOAD_WB -> r0 unchanged at 0, pc=0.
